// File: rtl/wc_pkg.sv
// Shared constants and types for the Winograd-core tile transmitter:
// word geometry, framing words and the transmit FSM state encoding.
package wc_pkg;

  localparam int DW         = 10;
  localparam int NWORDS     = 16;
  localparam int IDXW       = 4;
  localparam int ROW_STRIDE = 4;
  localparam int NROWS      = NWORDS / ROW_STRIDE;

  localparam logic [DW-1:0] HDR    = 10'h3FF;
  localparam logic [DW-1:0] IDLE_W = 10'h000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } tx_state_e;

  // Row-major position of element (row, col) within a 4x4 tile.
  function automatic int word_index(input int row, input int col);
    return ROW_STRIDE * row + col;
  endfunction

endpackage

// File: rtl/wc_tile_buf.sv
// Shadow + active tile register pair. A tile is loaded into shadow; a transfer
// copies shadow into active and frees shadow. Active words are read by index.
module wc_tile_buf
  import wc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DW*NWORDS-1:0] tile,
  input  logic                 xfer,
  input  logic [IDXW-1:0]      sel,
  output logic [DW-1:0]        word,
  output logic                 shadow_full
);

  logic [DW-1:0] tile_words [NWORDS];
  logic [DW-1:0] shadow_reg [NWORDS];
  logic [DW-1:0] active_reg [NWORDS];
  logic          full_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NROWS; gi++) begin : g_row
      for (gj = 0; gj < ROW_STRIDE; gj++) begin : g_col
        localparam int K = word_index(gi, gj);
        assign tile_words[K] = tile[DW*K +: DW];
      end
    end
  endgenerate

  // load and xfer are mutually exclusive: load needs shadow empty, xfer needs it full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_reg <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      if (load) begin
        shadow_reg <= tile_words;
        full_reg   <= 1'b1;
      end else if (xfer) begin
        active_reg <= shadow_reg;
        full_reg   <= 1'b0;
      end
    end
  end

  assign word        = active_reg[sel];
  assign shadow_full = full_reg;

endmodule

// File: rtl/wc_tile_tx.sv
// Host-side transmitter: serialises accepted 4x4 tiles onto D as
// header + 16 data words, back-to-back when a second tile is buffered.
module wc_tile_tx
  import wc_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW*NWORDS-1:0] in_tile,
  output logic [DW-1:0]        D,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CW-1:0]        frame_cnt
);

  localparam logic [IDXW-1:0] LAST = IDXW'(NWORDS - 1);

  tx_state_e       state_reg, state_next;
  logic [IDXW-1:0] idx_reg, idx_next, sel;
  logic [DW-1:0]   d_reg, d_next, word;
  logic [CW-1:0]   frame_cnt_reg, frame_cnt_next;
  logic            shadow_full, load, xfer;

  assign in_ready = ~shadow_full;
  assign load     = in_valid & ~shadow_full;

  wc_tile_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .tile        (in_tile),
    .xfer        (xfer),
    .sel         (sel),
    .word        (word),
    .shadow_full (shadow_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      d_reg         <= IDLE_W;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      d_reg         <= d_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  // idx_reg is the index of the data word currently on D.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    d_next         = d_reg;
    frame_cnt_next = frame_cnt_reg;
    xfer           = 1'b0;
    sel            = '0;
    case (state_reg)
      ST_IDLE: begin
        d_next = IDLE_W;
        if (shadow_full) begin
          xfer       = 1'b1;
          d_next     = HDR;
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        sel        = '0;
        d_next     = word;
        idx_next   = '0;
        state_next = ST_DATA;
      end
      ST_DATA: begin
        if (idx_reg != LAST) begin
          sel      = idx_reg + IDXW'(1);
          d_next   = word;
          idx_next = sel;
        end else begin
          frame_cnt_next = frame_cnt_reg + CW'(1);
          if (shadow_full) begin
            xfer       = 1'b1;
            d_next     = HDR;
            state_next = ST_HDR;
          end else begin
            d_next     = IDLE_W;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign D          = d_reg;
  assign busy       = (state_reg != ST_IDLE) | shadow_full;
  assign frame_done = (state_reg == ST_DATA) && (idx_reg == LAST);
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_wc_tile_tx.sv
// Directed bench for wc_tile_tx: reset state, single and back-to-back frames,
// backpressure, mid-frame reset and frame counter wrap.
module tb_wc_tile_tx;
  import wc_pkg::*;

  localparam int TW = DW * NWORDS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_tile = '0;
  logic [DW-1:0] D;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [TW-1:0] tile_q[$];
  logic [DW-1:0] exp_d[$];
  logic          exp_done[$];
  logic          ready_log[$];

  always #5 clk = ~clk;

  wc_tile_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tile    (in_tile),
    .D          (D),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: word k = k+1; mode 1: every word = v; mode 2: word k = 37*k + v
  function automatic logic [TW-1:0] make_tile(input int mode, input logic [DW-1:0] v);
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (mode == 0)      t[DW*k +: DW] = DW'(k + 1);
      else if (mode == 1) t[DW*k +: DW] = v;
      else                t[DW*k +: DW] = DW'(37 * k) + v;
    end
    return t;
  endfunction

  // Queued tiles offered from cycle 0 go out back-to-back: two idle cycles,
  // then header + 16 words per tile, then idle.
  task automatic build_expect(input int tail);
    exp_d.delete();
    exp_done.delete();
    repeat (2) begin exp_d.push_back(IDLE_W); exp_done.push_back(1'b0); end
    foreach (tile_q[i]) begin
      logic [TW-1:0] t;
      t = tile_q[i];
      exp_d.push_back(HDR);
      exp_done.push_back(1'b0);
      for (int k = 0; k < NWORDS; k++) begin
        exp_d.push_back(t[DW*k +: DW]);
        exp_done.push_back(k == NWORDS - 1);
      end
    end
    repeat (tail) begin exp_d.push_back(IDLE_W); exp_done.push_back(1'b0); end
  endtask

  task automatic run_stream(input string name, input int ncyc);
    ready_log.delete();
    for (int c = 0; c < ncyc; c++) begin
      logic fire;
      if (tile_q.size() > 0) begin
        in_valid = 1'b1;
        in_tile  = tile_q[0];
      end else begin
        in_valid = 1'b0;
      end
      fire = in_valid && in_ready;
      ready_log.push_back(in_ready);
      check($sformatf("%s D[%0d]", name, c), 32'(D), 32'(exp_d[c]));
      check($sformatf("%s done[%0d]", name, c), 32'(frame_done), 32'(exp_done[c]));
      step();
      if (fire) begin
        void'(tile_q.pop_front());
        $display("%s: tile accepted at end of cycle %0d", name, c);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst D", 32'(D), 32'(IDLE_W));
    check("rst ready", 32'(in_ready), 32'd1);
    check("rst cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    // Power-on reset and 50 quiet cycles.
    #12;
    check("por D", 32'(D), 32'(IDLE_W));
    check("por ready", 32'(in_ready), 32'd1);
    check("por busy", 32'(busy), 32'd0);
    check("por done", 32'(frame_done), 32'd0);
    check("por cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int c = 0; c < 50; c++) begin
      check("quiet D", 32'(D), 32'(IDLE_W));
      check("quiet ready", 32'(in_ready), 32'd1);
      check("quiet busy", 32'(busy), 32'd0);
      check("quiet cnt", 32'(frame_cnt), 32'd0);
      step();
    end
    $display("quiet: 50 idle cycles observed");

    // Single tile, word k = k+1.
    tile_q.push_back(make_tile(0, '0));
    build_expect(4);
    run_stream("single", exp_d.size());
    check("single cnt", 32'(frame_cnt), 32'd1);
    check("single busy", 32'(busy), 32'd0);
    check("single queue", 32'(tile_q.size()), 32'd0);

    // Two tiles back-to-back with in_valid held high.
    do_reset();
    tile_q.push_back(make_tile(1, 10'h155));
    tile_q.push_back(make_tile(1, 10'h2AA));
    build_expect(3);
    run_stream("pair", exp_d.size());
    check("pair ready@xfer", 32'(ready_log[1]), 32'd0);
    check("pair ready after", 32'(ready_log[2]), 32'd1);
    check("pair cnt", 32'(frame_cnt), 32'd2);
    check("pair queue", 32'(tile_q.size()), 32'd0);

    // Three tiles: third held off while shadow is full; C contains HDR-valued words.
    do_reset();
    tile_q.push_back(make_tile(2, 10'h001));
    tile_q.push_back(make_tile(2, 10'h100));
    tile_q.push_back(make_tile(1, HDR));
    build_expect(3);
    run_stream("triple", exp_d.size());
    check("triple ready c1", 32'(ready_log[1]), 32'd0);
    check("triple ready c10", 32'(ready_log[10]), 32'd0);
    check("triple ready c18", 32'(ready_log[18]), 32'd0);
    check("triple ready c19", 32'(ready_log[19]), 32'd1);
    check("triple cnt", 32'(frame_cnt), 32'd3);
    check("triple queue", 32'(tile_q.size()), 32'd0);

    // Reset while word 7 is on D and a second tile sits in shadow.
    tile_q.push_back(make_tile(2, 10'h055));
    tile_q.push_back(make_tile(1, 10'h0F0));
    build_expect(0);
    run_stream("midrst", 10);
    check("midrst word7", 32'(D), 32'(exp_d[10]));
    check("midrst ready pre", 32'(in_ready), 32'd0);
    check("midrst busy pre", 32'(busy), 32'd1);
    check("midrst cnt pre", 32'(frame_cnt), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("midrst D", 32'(D), 32'(IDLE_W));
    check("midrst ready", 32'(in_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst cnt", 32'(frame_cnt), 32'd0);
    tile_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int c = 0; c < 30; c++) begin
      check("post-rst D", 32'(D), 32'(IDLE_W));
      check("post-rst busy", 32'(busy), 32'd0);
      check("post-rst done", 32'(frame_done), 32'd0);
      step();
    end
    $display("midrst: buffered tile discarded");

    // Frame counter wrap from 16'hFFFF.
    force dut.frame_cnt_reg = 16'hFFFF;
    step();
    release dut.frame_cnt_reg;
    step();
    check("wrap preload", 32'(frame_cnt), 32'h0000FFFF);
    tile_q.push_back(make_tile(0, '0));
    build_expect(2);
    run_stream("wrap", exp_d.size());
    check("wrap cnt", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
